fwd_tagger: RTL and testbench
=============================

FWD_TAGGER -- requirements
Module: fwd_tagger

Interface
REQ-001 Parameter: CELL_LEN, default 27, cell length in 16-bit words including the header word; legal range 2..256.
REQ-002 clk  input  1  single clock; all logic rises on posedge clk.
REQ-003 rst  input  1  reset, synchronous to clk, active-high.
REQ-004 in_valid  input  1  an input word is present.
REQ-005 in_sop  input  1  the input word is a cell header.
REQ-006 in_data  input  16  input word; for a header, [7:0] is the VPI lookup key.
REQ-007 in_ready  output  1  the block accepts the input word this cycle.
REQ-008 fwd_rden  output  1  lookup read strobe to the forwarding table.
REQ-009 fwd_addr  output  8  lookup address.
REQ-010 fwd_data  input  16  lookup result, valid in the cycle after fwd_rden; [15:8] is the port map, [7:0] is the new VPI.
REQ-011 out_valid  output  1  an output word is present.
REQ-012 out_sop  output  1  the output word is a translated header.
REQ-013 out_eop  output  1  the output word is the last word of the cell.
REQ-014 out_data  output  16  output word.
REQ-015 out_port  output  8  port map; stable for the whole cell.
REQ-016 out_ready  input  1  the downstream stage accepts the output word.
REQ-017 err_cnt  output  16  saturating count of discarded words.

Function
REQ-018 The FSM states SHALL be IDLE, LKUP, WAIT, HDR, BODY, plus DROP when FWD_TAG_DROP_EN is defined.
REQ-019 In IDLE, in_ready=1 and out_valid=0.
  - in_valid&in_sop: the header is registered and the FSM goes to LKUP.
  - in_valid&!in_sop: the word is discarded and err_cnt increments.
REQ-020 In LKUP, the block drives fwd_rden=1 for exactly one cycle with fwd_addr=hdr[7:0], then goes to WAIT; in_ready=0.
REQ-021 In WAIT, the block captures fwd_data into an entry register, then goes to HDR; in_ready=0.
REQ-022 In HDR, the outputs are:
  - out_valid=1, out_sop=1;
  - out_data={hdr[15:8], entry[7:0]};
  - out_port=entry[15:8].
  All are held until out_ready; then the word counter loads 1 and the FSM goes to BODY.
REQ-023 In BODY, the path is combinational pass-through:
  - out_valid=in_valid, in_ready=out_ready;
  - out_data=in_data, out_sop=0.
  The counter increments on each transfer (in_valid&out_ready).
REQ-024 out_eop=1 on the BODY word where counter==CELL_LEN-1; that transfer returns the FSM to IDLE.
REQ-025 in_sop during BODY SHALL be ignored; cells are fixed length and the word passes as data.
REQ-026 Latency: header accepted at cycle N gives fwd_rden at N+1 and out_valid (header) at N+3.
REQ-027 At most one lookup is outstanding; no new header is accepted before the previous cell's out_eop transfer.
REQ-028 fwd_addr SHALL hold its last value when fwd_rden=0.
REQ-029 err_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-030 While rst=1, the following hold at the next edge and thereafter while reset persists:
  - state=IDLE, in_ready=0;
  - out_valid=0, out_sop=0, out_eop=0;
  - fwd_rden=0, fwd_addr=0;
  - out_data=0, out_port=0, err_cnt=0, counter=0.
REQ-031 Reset asserted mid-cell SHALL abandon the cell without emitting out_eop; in_ready=1 from the first cycle after rst falls.

Configuration
REQ-032 Macro FWD_TAG_DROP_EN. When defined:
  - WAIT with fwd_data[15:8]==0 goes to DROP instead of HDR.
  - DROP sets in_ready=1 and out_valid=0, consumes CELL_LEN-1 words, returns to IDLE, and increments err_cnt once per dropped cell.
REQ-033 Without FWD_TAG_DROP_EN, a cell with a zero port map SHALL be forwarded normally with out_port=0.

Structure
REQ-034 Package fwd_pkg SHALL hold:
  - the state enum;
  - entry field positions (PORT_MSB=15, PORT_LSB=8, VPI_MSB=7, VPI_LSB=0);
  - the CELL_LEN default.
REQ-035 One sub-module, sat_cnt16 (16-bit saturating incrementer with synchronous clear), SHALL implement err_cnt; the FSM stays in fwd_tagger.

Verification
REQ-036 Table addr 8'h05=16'h0233, header 16'hAB05, CELL_LEN=4, out_ready=1 -> fwd_rden at N+1 with fwd_addr=8'h05; out_data=16'hAB33 with out_sop=1 and out_port=8'h02 at N+3; 3 body words follow with out_eop on the third.
REQ-037 Non-sop words 16'h1111, 16'h2222 arriving in IDLE -> no output, no fwd_rden, err_cnt=2.
REQ-038 out_ready=0 for 5 cycles during HDR and again mid-BODY -> header and body words held stable, in_ready=0 throughout, no word lost or duplicated.
REQ-039 Entry 16'h0077 with FWD_TAG_DROP_EN -> no out_valid for the cell, err_cnt+1, next cell forwarded normally; same entry without the macro -> cell forwarded with out_port=0.
REQ-040 rst pulsed on the second body word -> outputs zero, no out_eop, and the next header is accepted cleanly; back-to-back cells -> second header accepted in the cycle after the first cell's eop transfer.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and constants for the VPI forwarding tagger.
// FWD_TAG_DROP_EN adds the DROP state for cells whose lookup returns an empty port map.
package fwd_pkg;

    localparam int CELL_LEN_DEF = 27;

    localparam int PORT_MSB = 15;
    localparam int PORT_LSB = 8;
    localparam int VPI_MSB  = 7;
    localparam int VPI_LSB  = 0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LKUP = 3'd1,
        S_WAIT = 3'd2,
        S_HDR  = 3'd3,
        S_BODY = 3'd4
`ifdef FWD_TAG_DROP_EN
        ,
        S_DROP = 3'd5
`endif
    } state_e;

endpackage

// File: rtl/fwd_tagger_if.sv
// Cell stream in/out plus forwarding-table lookup port of the tagger.
// The slave modport is the tagger's view; master is the surrounding pipeline's view.
interface fwd_tagger_if;
    logic        in_valid;
    logic        in_sop;
    logic [15:0] in_data;
    logic        in_ready;

    logic        fwd_rden;
    logic [7:0]  fwd_addr;
    logic [15:0] fwd_data;

    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic [15:0] out_data;
    logic [7:0]  out_port;
    logic        out_ready;

    modport slave (
        input  in_valid, in_sop, in_data, fwd_data, out_ready,
        output in_ready, fwd_rden, fwd_addr, out_valid, out_sop, out_eop, out_data, out_port
    );

    modport master (
        output in_valid, in_sop, in_data, fwd_data, out_ready,
        input  in_ready, fwd_rden, fwd_addr, out_valid, out_sop, out_eop, out_data, out_port
    );
endinterface

// File: rtl/sat_cnt16.sv
// 16-bit incrementer that sticks at all-ones; synchronous clear has priority.
module sat_cnt16 (
    input  logic        clk,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clr_i)
            cnt_q <= '0;
        else if (inc_i && (cnt_q != 16'hFFFF))
            cnt_q <= cnt_q + 16'd1;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/fwd_tagger.sv
// Rewrites the VPI of each fixed-length cell header from a one-read-latency table
// and tags the cell with its port map. FWD_TAG_DROP_EN discards cells with a zero port map.
module fwd_tagger
    import fwd_pkg::*;
#(
    parameter int CELL_LEN = CELL_LEN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    fwd_tagger_if.slave        bus,
    output logic [15:0]        err_cnt
);
    localparam logic [8:0] LAST = 9'(CELL_LEN - 1);

    state_e      state_q, state_d;
    logic [7:0]  hdr_q, hdr_d;      // header bits kept for the rewritten word
    logic [7:0]  addr_q, addr_d;
    logic [15:0] entry_q, entry_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        err_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hdr_q   <= '0;
            addr_q  <= '0;
            entry_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            addr_q  <= addr_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hdr_d         = hdr_q;
        addr_d        = addr_q;
        entry_d       = entry_q;
        cnt_d         = cnt_q;
        err_inc       = 1'b0;
        bus.in_ready  = 1'b0;
        bus.fwd_rden  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_sop   = 1'b0;
        bus.out_eop   = 1'b0;
        bus.out_data  = '0;

        case (state_q)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (bus.in_sop) begin
                        hdr_d   = bus.in_data[15:8];
                        addr_d  = bus.in_data[VPI_MSB:VPI_LSB];
                        state_d = S_LKUP;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            S_LKUP: begin
                bus.fwd_rden = 1'b1;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                entry_d = bus.fwd_data;
                state_d = S_HDR;
`ifdef FWD_TAG_DROP_EN
                if (bus.fwd_data[PORT_MSB:PORT_LSB] == 8'h00) begin
                    cnt_d   = 9'd1;
                    err_inc = 1'b1;
                    state_d = S_DROP;
                end
`endif
            end
            S_HDR: begin
                bus.out_valid = 1'b1;
                bus.out_sop   = 1'b1;
                bus.out_data  = {hdr_q, entry_q[VPI_MSB:VPI_LSB]};
                if (bus.out_ready) begin
                    cnt_d   = 9'd1;
                    state_d = S_BODY;
                end
            end
            S_BODY: begin
                // in_sop is ignored here: cells are fixed length.
                bus.out_valid = bus.in_valid;
                bus.in_ready  = bus.out_ready;
                bus.out_data  = bus.in_data;
                bus.out_eop   = (cnt_q == LAST);
                if (bus.in_valid && bus.out_ready) begin
                    cnt_d = cnt_q + 9'd1;
                    if (cnt_q == LAST)
                        state_d = S_IDLE;
                end
            end
`ifdef FWD_TAG_DROP_EN
            S_DROP: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    cnt_d = cnt_q + 9'd1;
                    if (cnt_q == LAST)
                        state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Reset blanks the stream immediately so an abandoned cell never shows eop.
        if (rst) begin
            bus.in_ready  = 1'b0;
            bus.fwd_rden  = 1'b0;
            bus.out_valid = 1'b0;
            bus.out_sop   = 1'b0;
            bus.out_eop   = 1'b0;
            bus.out_data  = '0;
        end
    end

    assign bus.fwd_addr = addr_q;
    assign bus.out_port = entry_q[PORT_MSB:PORT_LSB];

    sat_cnt16 u_err_cnt (
        .clk   (clk),
        .clr_i (rst),
        .inc_i (err_inc),
        .cnt_o (err_cnt)
    );
endmodule

// File: tb/tb_fwd_tagger.sv
// Scoreboard bench for fwd_tagger with CELL_LEN=4 and a modelled one-cycle lookup table.
module tb_fwd_tagger;
    localparam int CL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] err_cnt;

    fwd_tagger_if bus();

    fwd_tagger #(.CELL_LEN(CL)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    logic [15:0] tbl [256];
    always @(posedge clk) if (bus.fwd_rden) bus.fwd_data <= tbl[bus.fwd_addr];

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [15:0] data;
        logic [7:0]  port;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   rd_cnt = 0;
    int   exp_err = 0;
    logic acc;

    // One clock: sample at negedge, pop/compare any output transfer, return 1ns after posedge.
    task automatic tick();
        exp_t e, got;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready && !rst;
        if (bus.fwd_rden) rd_cnt++;
        if (bus.out_valid && bus.out_ready && !rst) begin
            got = '{bus.out_sop, bus.out_eop, bus.out_data, bus.out_port};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected got sop=%0b eop=%0b data=%h port=%h, none expected",
                         got.sop, got.eop, got.data, got.port);
            end else begin
                e = q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL out_word got sop=%0b eop=%0b data=%h port=%h want sop=%0b eop=%0b data=%h port=%h",
                             got.sop, got.eop, got.data, got.port, e.sop, e.eop, e.data, e.port);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic sop, input logic [15:0] d, output int waited);
        bus.in_valid = 1'b1;
        bus.in_sop   = sop;
        bus.in_data  = d;
        waited = 0;
        acc = 1'b0;
        while (!acc && waited < 50) begin
            tick();
            waited++;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL handshake_timeout data=%h not accepted, want accepted within 50 cycles", d);
        end
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
    endtask

    task automatic send_cell(input logic [15:0] hdr, output int hdr_wait);
        logic [15:0] e, d;
        logic        drop;
        int          w;
        e = tbl[hdr[7:0]];
`ifdef FWD_TAG_DROP_EN
        drop = (e[15:8] == 8'h00);
`else
        drop = 1'b0;
`endif
        if (drop) exp_err++;
        else q.push_back('{1'b1, 1'b0, {hdr[15:8], e[7:0]}, e[15:8]});
        send_word(1'b1, hdr, hdr_wait);
        for (int i = 0; i < CL - 1; i++) begin
            d = {hdr[7:0] ^ 8'(i * 37), 8'(i + 1)};
            if (!drop) q.push_back('{1'b0, (i == CL - 2), d, e[15:8]});
            send_word(i == 1, d, w);  // stray sop mid-cell must pass as data
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_sop !== 1'b0 || bus.out_eop !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b vld=%b sop=%b eop=%b want 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_sop, bus.out_eop);
        end
        checks++;
        if (bus.fwd_rden !== 1'b0 || bus.fwd_addr !== 8'h00 || bus.out_data !== 16'h0 || bus.out_port !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got rden=%b addr=%h data=%h port=%h want 0 00 0000 00",
                     bus.fwd_rden, bus.fwd_addr, bus.out_data, bus.out_port);
        end
        checks++;
        if (err_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_err got %h want 0000", err_cnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_nonsop();
        int rd0, w;
        rd0 = rd_cnt;
        send_word(1'b0, 16'h1111, w);
        send_word(1'b0, 16'h2222, w);
        tick();
        exp_err += 2;
        checks++;
        if (err_cnt !== 16'(exp_err)) begin
            errors++;
            $display("FAIL nonsop_err got %0d want %0d", err_cnt, exp_err);
        end
        checks++;
        if (rd_cnt != rd0) begin
            errors++;
            $display("FAIL nonsop_rden got %0d reads want 0", rd_cnt - rd0);
        end
    endtask

    task automatic test_basic();
        int rd0, w;
        logic [15:0] d;
        tbl[8'h05] = 16'h0233;
        rd0 = rd_cnt;
        bus.in_valid = 1'b1; bus.in_sop = 1'b1; bus.in_data = 16'hAB05;
        tick();
        bus.in_valid = 1'b0; bus.in_sop = 1'b0;
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL basic_hdr_accept got %b want 1", acc);
        end
        q.push_back('{1'b1, 1'b0, 16'hAB33, 8'h02});
        checks++;
        if (bus.fwd_rden !== 1'b1 || bus.fwd_addr !== 8'h05 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_lkup got rden=%b addr=%h rdy=%b want 1 05 0", bus.fwd_rden, bus.fwd_addr, bus.in_ready);
        end
        tick();
        checks++;
        if (bus.fwd_rden !== 1'b0 || bus.fwd_addr !== 8'h05 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_wait got rden=%b addr=%h vld=%b want 0 05 0", bus.fwd_rden, bus.fwd_addr, bus.out_valid);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sop !== 1'b1 || bus.out_data !== 16'hAB33 || bus.out_port !== 8'h02) begin
            errors++;
            $display("FAIL basic_hdr got vld=%b sop=%b data=%h port=%h want 1 1 ab33 02",
                     bus.out_valid, bus.out_sop, bus.out_data, bus.out_port);
        end
        for (int i = 0; i < CL - 1; i++) begin
            d = 16'hC000 + 16'(i);
            q.push_back('{1'b0, (i == CL - 2), d, 8'h02});
            send_word(1'b0, d, w);
        end
        checks++;
        if (q.size() != 0 || rd_cnt != rd0 + 1) begin
            errors++;
            $display("FAIL basic_done got pending=%0d reads=%0d want 0 1", q.size(), rd_cnt - rd0);
        end
    endtask

    task automatic test_backpressure();
        int w;
        tbl[8'h21] = 16'h0455;
        q.push_back('{1'b1, 1'b0, 16'h5A55, 8'h04});
        send_word(1'b1, 16'h5A21, w);
        tick();
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_sop !== 1'b1 || bus.out_data !== 16'h5A55 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hdr_hold got vld=%b sop=%b data=%h rdy=%b want 1 1 5a55 0",
                         bus.out_valid, bus.out_sop, bus.out_data, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        q.push_back('{1'b0, 1'b0, 16'hB001, 8'h04});
        send_word(1'b0, 16'hB001, w);
        q.push_back('{1'b0, 1'b0, 16'hB002, 8'h04});
        bus.in_valid = 1'b1; bus.in_sop = 1'b0; bus.in_data = 16'hB002;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (acc !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 16'hB002 || bus.out_eop !== 1'b0) begin
                errors++;
                $display("FAIL bp_body_hold got acc=%b rdy=%b vld=%b data=%h eop=%b want 0 0 1 b002 0",
                         acc, bus.in_ready, bus.out_valid, bus.out_data, bus.out_eop);
            end
        end
        bus.out_ready = 1'b1;
        send_word(1'b0, 16'hB002, w);
        q.push_back('{1'b0, 1'b1, 16'hB003, 8'h04});
        send_word(1'b0, 16'hB003, w);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL bp_done got pending=%0d want 0", q.size());
        end
    endtask

    task automatic test_zero_port();
        int w;
        tbl[8'h10] = 16'h0077;
        tbl[8'h11] = 16'h0312;
        send_cell(16'hCD10, w);
        tick();
        checks++;
        if (err_cnt !== 16'(exp_err) || q.size() != 0) begin
            errors++;
            $display("FAIL zero_port got err=%0d pending=%0d want %0d 0", err_cnt, q.size(), exp_err);
        end
        send_cell(16'hEE11, w);
        checks++;
        if (q.size() != 0 || err_cnt !== 16'(exp_err)) begin
            errors++;
            $display("FAIL zero_port_next got pending=%0d err=%0d want 0 %0d", q.size(), err_cnt, exp_err);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        tbl[8'h30] = 16'h0540;
        tbl[8'h31] = 16'h0641;
        q.push_back('{1'b1, 1'b0, 16'h1240, 8'h05});
        send_word(1'b1, 16'h1230, w);
        q.push_back('{1'b0, 1'b0, 16'hD000, 8'h05});
        send_word(1'b0, 16'hD000, w);
        bus.in_valid = 1'b1; bus.in_data = 16'hD001;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_eop !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_gate got vld=%b eop=%b rdy=%b want 0 0 0", bus.out_valid, bus.out_eop, bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_data !== 16'h0 || bus.out_port !== 8'h00 || err_cnt !== 16'h0 || bus.fwd_addr !== 8'h00 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_zero got data=%h port=%h err=%h addr=%h vld=%b want 0000 00 0000 00 0",
                     bus.out_data, bus.out_port, err_cnt, bus.fwd_addr, bus.out_valid);
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        q.delete();
        exp_err = 0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready got %b want 1", bus.in_ready);
        end
        send_cell(16'h7731, w);
        checks++;
        if (w != 1 || q.size() != 0) begin
            errors++;
            $display("FAIL rstmid_next got hdr_wait=%0d pending=%0d want 1 0", w, q.size());
        end
    endtask

    task automatic test_back_to_back();
        int w;
        tbl[8'h40] = 16'h0A0B;
        tbl[8'h41] = 16'h0C0D;
        send_cell(16'h9140, w);
        send_cell(16'h9241, w);
        checks++;
        if (w != 1) begin
            errors++;
            $display("FAIL b2b_hdr_wait got %0d cycles want 1", w);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL b2b_done got pending=%0d want 0", q.size());
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sop    = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) tbl[i] = {8'(i) ^ 8'h5A, 8'(i)};
        test_reset();
        test_nonsop();
        test_basic();
        test_backpressure();
        test_zero_port();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
